time_field_counter: RTL

Parametrised two-digit BCD time-field counter with registered 7-segment outputs. It is the successor to the fixed mod-60 minute/second digit pair. It runs on the single system clock, uses a one-cycle count-enable tick instead of ripple clocks, and supports programmable modulus and base value (mod-60, mod-24, 1..12). It adds a set mode with increment, decrement, blink and parallel load, and a carry pulse that chains directly into the next field's tick input (seconds → minutes → hours).

---
 rtl/time_field_counter_if.sv | 26 ++
 rtl/time_field_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/time_field_counter_if.sv
// Control and display signals of one BCD time field.
// The master drives the controls and the slave is the counter.
interface time_field_counter_if;
    logic       tick_in;
    logic       set_en;
    logic       inc;
    logic       dec;
    logic       blink;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] bcd_out;
    logic       carry_out;
    logic       load_err;
    logic [7:0] seg_tens;
    logic [7:0] seg_ones;

    modport master (
        output tick_in, set_en, inc, dec, blink, load, load_val,
        input  bcd_out, carry_out, load_err, seg_tens, seg_ones
    );

    modport slave (
        input  tick_in, set_en, inc, dec, blink, load, load_val,
        output bcd_out, carry_out, load_err, seg_tens, seg_ones
    );
endinterface

// File: rtl/time_field_counter.sv
// Two-digit BCD time field with a programmable range (MIN_VAL..MAX_VAL),
// set mode, parallel load, a chainable carry pulse and registered
// 7-segment outputs.
module time_field_counter #(
    parameter int MODULUS        = 60,
    parameter int MIN_VAL        = 0,
    parameter int LZ_BLANK       = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    time_field_counter_if.slave  bus
);

    localparam int         MAX_VAL = MIN_VAL + MODULUS - 1;
    localparam logic [3:0] MIN_T   = 4'(MIN_VAL / 10);
    localparam logic [3:0] MIN_O   = 4'(MIN_VAL % 10);
    localparam logic [3:0] MAX_T   = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_O   = 4'(MAX_VAL % 10);

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    // Inversion comes after blanking so a blanked digit is all-off in either polarity.
    function automatic logic [7:0] seg_drive(input logic [3:0] d, input logic blank);
        logic [7:0] s;
        s = blank ? 8'h00 : seg_digit(d);
        if (SEG_ACTIVE_LOW != 0) s = ~s;
        return s;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd9) return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd0) return {t - 4'd1, 4'd9};
        return {t, o - 4'd1};
    endfunction

    localparam logic [7:0] RST_SEG_T = seg_drive(MIN_T, (LZ_BLANK != 0) && (MIN_T == 4'd0));
    localparam logic [7:0] RST_SEG_O = seg_drive(MIN_O, 1'b0);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       carry_q, carry_d;
    logic       err_q, err_d;
    logic [7:0] seg_tens_q, seg_tens_d;
    logic [7:0] seg_ones_q, seg_ones_d;

    logic       at_min, at_max;
    logic [7:0] load_num;
    logic       load_ok;
    logic       blank_all;

    assign at_min   = (tens_q == MIN_T) && (ones_q == MIN_O);
    assign at_max   = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign load_num = {4'd0, bus.load_val[7:4]} * 8'd10 + {4'd0, bus.load_val[3:0]};
    assign load_ok  = (bus.load_val[7:4] <= 4'd9) && (bus.load_val[3:0] <= 4'd9)
                      && (int'(load_num) >= MIN_VAL) && (int'(load_num) <= MAX_VAL);
    assign blank_all = bus.set_en && bus.blink;

    // One action per edge: load, then dec, then inc, then tick.
    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (bus.load) begin
            if (load_ok) {tens_d, ones_d} = bus.load_val;
            else         err_d = 1'b1;
        end else if (bus.set_en && bus.dec) begin
            if (at_min) {tens_d, ones_d} = {MAX_T, MAX_O};
            else        {tens_d, ones_d} = bcd_dec(tens_q, ones_q);
        end else if (bus.set_en && bus.inc) begin
            if (at_max) {tens_d, ones_d} = {MIN_T, MIN_O};
            else        {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
        end else if (!bus.set_en && bus.tick_in) begin
            if (at_max) begin
                {tens_d, ones_d} = {MIN_T, MIN_O};
                carry_d          = 1'b1;
            end else begin
                {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
            end
        end
    end

    // Segment encode of the current value; registered, so it lags bcd_out by a cycle.
    always_comb begin
        seg_tens_d = seg_drive(tens_q, blank_all || ((LZ_BLANK != 0) && (tens_q == 4'd0)));
        seg_ones_d = seg_drive(ones_q, blank_all);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q     <= MIN_T;
            ones_q     <= MIN_O;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            seg_tens_q <= RST_SEG_T;
            seg_ones_q <= RST_SEG_O;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
            seg_tens_q <= seg_tens_d;
            seg_ones_q <= seg_ones_d;
        end
    end

    assign bus.bcd_out   = {tens_q, ones_q};
    assign bus.carry_out = carry_q;
    assign bus.load_err  = err_q;
    assign bus.seg_tens  = seg_tens_q;
    assign bus.seg_ones  = seg_ones_q;

endmodule
